// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared types and helpers for the mem_arbiter block and its round-robin
//   picker.
//
//   Contents:
//     ADDR_WIDTH / DATA_WIDTH  default memory geometry (16 x 8)
//     addr_t / data_t          memory address / data words
//     lock_state_t             lock FSM states (used with MEM_ARBITER_LOCK_EN)
//     rr_next(ptr, n)          next round-robin position, wrapping at n
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 8;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    // Position after ptr in a ring of n ports.
    function automatic int unsigned rr_next(input int unsigned ptr,
                                            input int unsigned n);
        return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage : mem_arbiter_pkg

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
//   Purely combinational round-robin selector. Scans the request vector
//   starting at rr_ptr and wrapping modulo N; the first set bit wins.
//   Written to be reusable by other arbiters.
//
//   Parameters:
//     N      number of requesters
//     PTR_W  width of the pointer / index
//
//   Ports:
//     valid   in   N      request vector
//     rr_ptr  in   PTR_W  highest-priority position for this cycle
//     grant   out  N      one-hot grant (all zero when nothing is requested)
//     idx     out  PTR_W  binary index of the granted requester
//     any     out  1      a grant was made
// -----------------------------------------------------------------------------
module rr_picker
    import mem_arbiter_pkg::*;
#(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     valid,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    always_comb begin
        // NOTE: every output gets a default before the search so no path
        // through this block can hold a previous value and infer a latch.
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && valid[(int'(rr_ptr) + k) % N]) begin
                grant[(int'(rr_ptr) + k) % N] = 1'b1;
                idx = PTR_W'((int'(rr_ptr) + k) % N);
                any = 1'b1;
            end
        end
    end

endmodule : rr_picker

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port synchronous memory between N_PORTS requesters.
//   One access per cycle, round-robin fairness, one-cycle read latency with
//   a per-port read-valid strobe and a shared read-data bus.
//
//   Optional feature macro: MEM_ARBITER_LOCK_EN
//     Adds s_lock[N_PORTS] and a two-state lock FSM. A transfer with its
//     s_lock bit set makes that port the exclusive owner until it completes
//     a transfer with s_lock clear.
//
//   Parameters:
//     N_PORTS     number of requesters (2..4)
//     ADDR_WIDTH  memory address width
//     DATA_WIDTH  memory data width
//
//   Ports:
//     clk       in   1                      system clock
//     reset_n   in   1                      asynchronous active-low reset
//     s_valid   in   N_PORTS                per-port request valid
//     s_ready   out  N_PORTS                per-port grant / accept
//     s_we      in   N_PORTS                per-port 1 = write, 0 = read
//     s_addr    in   N_PORTS*ADDR_WIDTH     per-port address (port i at [i*AW +: AW])
//     s_wdata   in   N_PORTS*DATA_WIDTH     per-port write data
//     s_lock    in   N_PORTS                per-port lock request (MEM_ARBITER_LOCK_EN only)
//     s_rvalid  out  N_PORTS                per-port read-data-valid pulse
//     s_rdata   out  DATA_WIDTH             shared read data, zero when no s_rvalid
//     m_en      out  1                      memory enable
//     m_we      out  1                      memory write enable
//     m_addr    out  ADDR_WIDTH             memory address
//     m_wdata   out  DATA_WIDTH             memory write data
//     m_rdata   in   DATA_WIDTH             memory read data (registered in memory)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int N_PORTS    = 2,
    parameter int ADDR_WIDTH = mem_arbiter_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = mem_arbiter_pkg::DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [N_PORTS-1:0]            s_valid,
    output logic [N_PORTS-1:0]            s_ready,
    input  logic [N_PORTS-1:0]            s_we,
    input  logic [N_PORTS*ADDR_WIDTH-1:0] s_addr,
    input  logic [N_PORTS*DATA_WIDTH-1:0] s_wdata,
`ifdef MEM_ARBITER_LOCK_EN
    input  logic [N_PORTS-1:0]            s_lock,
`endif
    output logic [N_PORTS-1:0]            s_rvalid,
    output logic [DATA_WIDTH-1:0]         s_rdata,
    output logic                          m_en,
    output logic                          m_we,
    output logic [ADDR_WIDTH-1:0]         m_addr,
    output logic [DATA_WIDTH-1:0]         m_wdata,
    input  logic [DATA_WIDTH-1:0]         m_rdata
);

    import mem_arbiter_pkg::*;

    localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [N_PORTS-1:0] eff_valid;   // requests allowed to compete this cycle
    logic [N_PORTS-1:0] pick_grant;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;
    logic               fire;        // a transfer happens at the next edge
    logic               ptr_upd;     // this transfer advances the pointer

    rr_picker #(
        .N     (N_PORTS),
        .PTR_W (PTR_W)
    ) u_picker (
        .valid  (eff_valid),
        .rr_ptr (rr_ptr_q),
        .grant  (pick_grant),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Grants are suppressed while reset is asserted so no requester believes
    // it was accepted by a block that is not running.
    assign s_ready = reset_n ? pick_grant : '0;
    assign m_en    = reset_n & pick_any;
    assign fire    = m_en;

    // -------------------------------------------------------------------------
    // Memory drive: mux the granted port's request, zero when idle.
    // -------------------------------------------------------------------------
    always_comb begin
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (pick_any) begin
            m_we    = s_we[pick_idx];
            m_addr  = s_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            m_wdata = s_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // -------------------------------------------------------------------------
    // Optional lock FSM
    // -------------------------------------------------------------------------
`ifdef MEM_ARBITER_LOCK_EN
    lock_state_t        state_q, state_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [N_PORTS-1:0] owner_mask;

    always_comb begin
        owner_mask          = '0;
        owner_mask[owner_q] = 1'b1;
    end

    // While locked only the owner may compete; if it is idle nothing is
    // granted and the memory stays idle.
    assign eff_valid = (state_q == LOCKED) ? (s_valid & owner_mask) : s_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            IDLE: begin
                if (fire && s_lock[pick_idx]) begin
                    state_d = LOCKED;
                    owner_d = pick_idx;
                end
            end
            LOCKED: begin
                // Only the owner can fire here, so pick_idx == owner_q.
                if (fire && !s_lock[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The pointer is frozen for the duration of a lock; the releasing
    // transfer moves it past the owner like any ordinary transfer.
    assign ptr_upd = fire && ((state_q == IDLE) || (state_d == IDLE));
`else
    assign eff_valid = s_valid;
    assign ptr_upd   = fire;
`endif

    // -------------------------------------------------------------------------
    // Round-robin pointer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
        end else if (ptr_upd) begin
            // NOTE: state registers use non-blocking assignment so every
            // flop samples pre-edge values regardless of process order.
            rr_ptr_q <= PTR_W'(rr_next(32'(pick_idx), N_PORTS));
        end
    end

    // -------------------------------------------------------------------------
    // Read response: the memory registers its output, so the strobe is the
    // accepted read's grant delayed by one cycle. Reset drops a pending one.
    // -------------------------------------------------------------------------
    logic [N_PORTS-1:0] rvalid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid_q <= '0;
        end else begin
            rvalid_q <= (fire && !m_we) ? pick_grant : '0;
        end
    end

    assign s_rvalid = rvalid_q;
    assign s_rdata  = (|rvalid_q) ? m_rdata : '0;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Scoreboard bench for mem_arbiter. Stimulus pushes the expected grant of
//   each cycle and the expected read response of each accepted read; monitor
//   processes pop and compare whenever the DUT enables the memory or raises
//   s_rvalid. A second instance with three ports covers the fairness window.
//   Build with +define+MEM_ARBITER_LOCK_EN to include the lock sequence.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct {
        logic [1:0] port;
        data_t      data;
    } rd_exp_t;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // ---------------- two-port instance ----------------
    logic [1:0]  s_valid, s_ready, s_we, s_rvalid;
    logic [7:0]  s_addr;
    logic [15:0] s_wdata;
    data_t       s_rdata;
    logic        m_en, m_we;
    addr_t       m_addr;
    data_t       m_wdata, m_rdata;
`ifdef MEM_ARBITER_LOCK_EN
    logic [1:0]  s_lock;
`endif

    mem_arbiter #(.N_PORTS(2), .ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_we     (s_we),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
`ifdef MEM_ARBITER_LOCK_EN
        .s_lock   (s_lock),
`endif
        .s_rvalid (s_rvalid),
        .s_rdata  (s_rdata),
        .m_en     (m_en),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata)
    );

    // ---------------- three-port instance ----------------
    logic [2:0]  v3, r3, we3, rv3;
    logic [11:0] a3;
    logic [23:0] wd3;
    data_t       rd3;
    logic        m3_en, m3_we;
    addr_t       m3_addr;
    data_t       m3_wdata, m3_rdata;
`ifdef MEM_ARBITER_LOCK_EN
    logic [2:0]  lk3;
`endif

    mem_arbiter #(.N_PORTS(3), .ADDR_WIDTH(4), .DATA_WIDTH(8)) dut3 (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_valid  (v3),
        .s_ready  (r3),
        .s_we     (we3),
        .s_addr   (a3),
        .s_wdata  (wd3),
`ifdef MEM_ARBITER_LOCK_EN
        .s_lock   (lk3),
`endif
        .s_rvalid (rv3),
        .s_rdata  (rd3),
        .m_en     (m3_en),
        .m_we     (m3_we),
        .m_addr   (m3_addr),
        .m_wdata  (m3_wdata),
        .m_rdata  (m3_rdata)
    );

    // ---------------- memory models (16 x 8, power up to 0xFF) ----------------
    data_t mem  [16];
    data_t mem3 [16];

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]  = 8'hFF;
            mem3[i] = 8'hFF;
        end
        m_rdata  = '0;
        m3_rdata = '0;
    end

    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            else      m_rdata     <= mem[m_addr];
        end
        if (m3_en) begin
            if (m3_we) mem3[m3_addr] <= m3_wdata;
            else       m3_rdata      <= mem3[m3_addr];
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [1:0] gq  [$];
    rd_exp_t    rq  [$];
    logic [2:0] g3q [$];

    // Monitor for the two-port instance.
    always @(negedge clk) begin
        if (m_en) begin
            if (gq.size() == 0) check("grant_unexpected", 32'(s_ready), 32'h0);
            else                check("grant", 32'(s_ready), 32'(gq.pop_front()));
        end
        if (|s_rvalid) begin
            if (rq.size() == 0) begin
                check("rvalid_unexpected", 32'(s_rvalid), 32'h0);
            end else begin
                rd_exp_t e;
                e = rq.pop_front();
                check("rvalid_port", 32'(s_rvalid), 32'(e.port));
                check("rdata", 32'(s_rdata), 32'(e.data));
            end
        end else begin
            check("rdata_idle", 32'(s_rdata), 32'h0);
        end
    end

    // Monitor for the three-port instance.
    always @(negedge clk) begin
        if (m3_en) begin
            check("grant3_onehot", 32'($countones(r3)), 32'd1);
            if (g3q.size() == 0) check("grant3_unexpected", 32'(r3), 32'h0);
            else                 check("grant3", 32'(r3), 32'(g3q.pop_front()));
        end
        check("rvalid3_onehot0", 32'($onehot0(rv3)), 32'd1);
    end

    // ---------------- stimulus helpers ----------------
    // NOTE: inputs are driven with blocking assignments #1 after the edge,
    // well clear of the edge the DUT samples on.
    task automatic set_port(input int p, input logic v, input logic w,
                            input addr_t a, input data_t d);
        s_valid[p]         = v;
        s_we[p]            = w;
        s_addr[p*4 +: 4]   = a;
        s_wdata[p*8 +: 8]  = d;
    endtask

    // Record what this cycle should grant (and return, for a read), then
    // advance to just after the next rising edge.
    task automatic step(input logic [1:0] g, input bit rd, input data_t d);
        if (g != 2'b00) gq.push_back(g);
        if (rd) rq.push_back(rd_exp_t'{port: g, data: d});
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset_n = 1'b0;
        s_valid = '0; s_we = '0; s_addr = '0; s_wdata = '0;
        v3 = '0; we3 = '0; a3 = '0; wd3 = '0;
`ifdef MEM_ARBITER_LOCK_EN
        s_lock = '0;
        lk3    = '0;
`endif
        // Reset state: requests present but grants and enable are held low.
        #3;
        s_valid = 2'b11;
        #1;
        check("rst_ready", 32'(s_ready), 32'h0);
        check("rst_m_en", 32'(m_en), 32'h0);
        check("rst_rvalid", 32'(s_rvalid), 32'h0);
        check("rst_rdata", 32'(s_rdata), 32'h0);
        s_valid = 2'b00;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single requester: write 0xA5 to addr 3, read it back.
        set_port(0, 1'b1, 1'b1, 4'd3, 8'hA5);
        step(2'b01, 1'b0, 8'h00);
        set_port(0, 1'b1, 1'b0, 4'd3, 8'h00);
        step(2'b01, 1'b1, 8'hA5);
        set_port(0, 1'b0, 1'b0, 4'd0, 8'h00);
        step(2'b00, 1'b0, 8'h00);

        // Simultaneous reads from a fresh pointer: grants alternate 0,1,0,1.
        pulse_reset();
        set_port(0, 1'b1, 1'b0, 4'd0, 8'h00);
        set_port(1, 1'b1, 1'b0, 4'd1, 8'h00);
        step(2'b01, 1'b1, 8'hFF);
        step(2'b10, 1'b1, 8'hFF);
        step(2'b01, 1'b1, 8'hFF);
        step(2'b10, 1'b1, 8'hFF);
        set_port(0, 1'b0, 1'b0, 4'd0, 8'h00);
        set_port(1, 1'b0, 1'b0, 4'd0, 8'h00);
        step(2'b00, 1'b0, 8'h00);

        // Write then read of the same address on consecutive cycles.
        set_port(1, 1'b1, 1'b1, 4'd7, 8'h3C);
        step(2'b10, 1'b0, 8'h00);
        set_port(1, 1'b0, 1'b0, 4'd0, 8'h00);
        set_port(0, 1'b1, 1'b0, 4'd7, 8'h00);
        step(2'b01, 1'b1, 8'h3C);
        set_port(0, 1'b0, 1'b0, 4'd0, 8'h00);
        step(2'b00, 1'b0, 8'h00);

        // Mid-read reset: pointer is at 1 here; the read of addr 2 is accepted
        // and its response must vanish with the reset.
        set_port(0, 1'b1, 1'b0, 4'd2, 8'h00);
        step(2'b01, 1'b0, 8'h00);
        reset_n = 1'b0;
        set_port(0, 1'b0, 1'b0, 4'd0, 8'h00);
        #1;
        check("midrst_rvalid_in_reset", 32'(s_rvalid), 32'h0);
        check("midrst_rdata_in_reset", 32'(s_rdata), 32'h0);
        #1;
        reset_n = 1'b1;
        #1;
        check("midrst_rvalid_after", 32'(s_rvalid), 32'h0);
        // Pointer back at 0: with both requesting, port 0 wins first.
        set_port(0, 1'b1, 1'b0, 4'd0, 8'h00);
        set_port(1, 1'b1, 1'b0, 4'd1, 8'h00);
        step(2'b01, 1'b1, 8'hFF);
        set_port(0, 1'b0, 1'b0, 4'd0, 8'h00);
        step(2'b10, 1'b1, 8'hFF);
        set_port(1, 1'b0, 1'b0, 4'd0, 8'h00);
        step(2'b00, 1'b0, 8'h00);

`ifdef MEM_ARBITER_LOCK_EN
        // Lock: port 1 takes the lock, port 0 waits until the unlocked write.
        s_lock = 2'b10;
        set_port(1, 1'b1, 1'b0, 4'd5, 8'h00);
        step(2'b10, 1'b1, 8'hFF);
        set_port(1, 1'b0, 1'b0, 4'd0, 8'h00);
        set_port(0, 1'b1, 1'b0, 4'd0, 8'h00);
        #1;
        check("lock_owner_idle_ready", 32'(s_ready), 32'h0);
        check("lock_owner_idle_m_en", 32'(m_en), 32'h0);
        step(2'b00, 1'b0, 8'h00);
        set_port(1, 1'b1, 1'b0, 4'd5, 8'h00);
        step(2'b10, 1'b1, 8'hFF);
        s_lock = 2'b00;
        set_port(1, 1'b1, 1'b1, 4'd5, 8'h11);
        step(2'b10, 1'b0, 8'h00);
        set_port(1, 1'b0, 1'b0, 4'd0, 8'h00);
        step(2'b01, 1'b1, 8'hFF);
        set_port(0, 1'b1, 1'b0, 4'd5, 8'h00);
        step(2'b01, 1'b1, 8'h11);
        set_port(0, 1'b0, 1'b0, 4'd0, 8'h00);
        step(2'b00, 1'b0, 8'h00);
`endif

        // Starvation bound with three continuously valid ports.
        v3  = 3'b111;
        a3  = {4'd2, 4'd1, 4'd0};
        for (int w = 0; w < 3; w++) begin
            for (int p = 0; p < 3; p++) begin
                g3q.push_back(3'(1 << p));
                @(posedge clk);
                #1;
            end
        end
        v3 = 3'b000;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        check("grant_queue_drained", 32'(gq.size()), 32'd0);
        check("read_queue_drained", 32'(rq.size()), 32'd0);
        check("grant3_queue_drained", 32'(g3q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mem_arbiter
